customized_div: RTL and testbench



---
 rtl/customized_div_pkg.sv | 33 +++
 rtl/customized_mantissa_div_core.sv | 53 +++++
 rtl/customized_div.sv | 121 ++++++++++++
 tb/tb_customized_div.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/customized_div_pkg.sv
// Shared format constants, FSM encoding and field extraction for the
// customized {sign, exponent, mantissa} floating-point divider.
package customized_div_pkg;

  localparam int EXP_W    = 8;
  localparam int EXP_BIAS = 127;
  localparam int EXP_INF  = 255;
  localparam int MAX_MAN  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp;
    logic [MAX_MAN-1:0] man;
  } fp_fields_t;

  // man_len selects where the exponent and sign sit; the value is zero-extended
  function automatic fp_fields_t unpack_fp(input logic [MAX_MAN+EXP_W:0] val,
                                           input int man_len);
    fp_fields_t f;
    f.sign = val[man_len+EXP_W];
    f.exp  = val[man_len +: EXP_W];
    f.man  = val[MAX_MAN-1:0] & ((MAX_MAN'(1) << man_len) - MAX_MAN'(1));
    return f;
  endfunction

endpackage

// File: rtl/customized_mantissa_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first.
module customized_mantissa_div_core
  import customized_div_pkg::*;
#(
  parameter int W  = 24,
  parameter int QW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  num,
  input  logic [W-1:0]  den,
  output logic          last,
  output logic [QW-1:0] q
);

  localparam int CW = $clog2(QW + 1);

  logic [W:0]    rem;
  logic [W:0]    rem_diff;
  logic [W:0]    rem_next;
  logic [W-1:0]  den_r;
  logic [CW-1:0] cnt;
  logic          q_bit;

  // rem < 2*den holds throughout, so the shifted difference fits W+1 bits
  always_comb begin
    q_bit    = (rem >= {1'b0, den_r});
    rem_diff = q_bit ? (rem - {1'b0, den_r}) : rem;
    rem_next = rem_diff << 1;
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem   <= '0;
      den_r <= '0;
      q     <= '0;
      cnt   <= '0;
    end else if (start) begin
      rem   <= {1'b0, num};
      den_r <= den;
      q     <= '0;
      cnt   <= CW'(QW);
    end else if (cnt != '0) begin
      rem <= rem_next;
      q   <= {q[QW-2:0], q_bit};
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/customized_div.sv
// Sequential divider for the customized float format with valid/ready
// handshakes; specials bypass the iteration and go straight to DONE.
module customized_div
  import customized_div_pkg::*;
#(
  parameter int montissa_len_dividend = 23,
  parameter int montissa_len_divisor  = 23,
  parameter int montissa_len_result   = 23
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [montissa_len_dividend+EXP_W:0] dividend,
  input  logic [montissa_len_divisor+EXP_W:0]  divisor,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [montissa_len_result+EXP_W:0]   quotient,
  output logic                                 div_by_zero
);

  localparam int ML_A = montissa_len_dividend;
  localparam int ML_B = montissa_len_divisor;
  localparam int R    = montissa_len_result;
  localparam int W    = ((ML_A > ML_B) ? ML_A : ML_B) + 1;
  localparam int QW   = R + 2;
  localparam int OW   = R + EXP_W + 1;

  div_state_t state, state_next;

  fp_fields_t        fa, fb;
  logic [W-1:0]      num_al, den_al;
  logic signed [9:0] exp_diff_d, exp_diff_r;
  logic              sign_d, sign_r;
  logic              a_zero, b_zero, special, accept, core_start, core_last;
  logic [QW-1:0]     q;
  logic signed [10:0] e_norm;
  logic [R-1:0]      mant_n;
  logic [OW-1:0]     norm_word, special_word, quotient_r;
  logic              dbz_r;

  assign fa = unpack_fp((MAX_MAN+EXP_W+1)'(dividend), ML_A);
  assign fb = unpack_fp((MAX_MAN+EXP_W+1)'(divisor), ML_B);

  // Hidden-one mantissas left-aligned so both operands lie in [2^(W-1), 2^W)
  assign num_al = W'({1'b1, ML_A'(fa.man)}) << (W - 1 - ML_A);
  assign den_al = W'({1'b1, ML_B'(fb.man)}) << (W - 1 - ML_B);

  assign sign_d     = fa.sign ^ fb.sign;
  assign exp_diff_d = $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp});
  assign a_zero     = (fa.exp == '0);
  assign b_zero     = (fb.exp == '0);
  assign special    = a_zero | b_zero;
  assign accept     = (state == IDLE) && in_valid;
  assign core_start = accept && !special;

  assign special_word = b_zero ? {sign_d, EXP_W'(EXP_INF), R'(0)} : {sign_d, EXP_W'(0), R'(0)};

  customized_mantissa_div_core #(.W(W), .QW(QW)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .num   (num_al),
    .den   (den_al),
    .last  (core_last),
    .q     (q)
  );

  // Quotient lies in (0.5, 2): the top bit picks the normalisation shift
  always_comb begin
    e_norm = {exp_diff_r[9], exp_diff_r} + 11'sd127 - (q[QW-1] ? 11'sd0 : 11'sd1);
    mant_n = q[QW-1] ? q[R:1] : q[R-1:0];
    if (e_norm <= 11'sd0)
      norm_word = {sign_r, EXP_W'(0), R'(0)};
    else if (e_norm >= 11'(EXP_INF))
      norm_word = {sign_r, EXP_W'(EXP_INF), R'(0)};
    else
      norm_word = {sign_r, EXP_W'(e_norm), mant_n};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = special ? DONE : DIV;
      DIV:  if (core_last) state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sign_r     <= 1'b0;
      exp_diff_r <= '0;
      quotient_r <= '0;
      dbz_r      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        sign_r     <= sign_d;
        exp_diff_r <= exp_diff_d;
        if (special) begin
          quotient_r <= special_word;
          dbz_r      <= b_zero;
        end
      end
      if (state == NORM) begin
        quotient_r <= norm_word;
        dbz_r      <= 1'b0;
      end
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quotient_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_customized_div.sv
// Self-checking bench for customized_div: vector table driven through a
// scoreboard queue, plus handshake, input-noise and mid-operation reset sequences.
module tb_customized_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;

  always #5 clk = ~clk;

  customized_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    int          lat;
    int          hold;
    bit          noise;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Latency = rising edges after the acceptance edge until out_valid is seen
  task automatic issue(input vec_t v);
    int          lat;
    int          guard;
    logic [31:0] held;
    exp_t        e;
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    sb.push_back('{q: v.q, dbz: v.dbz});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (v.noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(v.lat));
    check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
    held = quotient;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_quotient", {32'd0, quotient}, {32'd0, held});
      check("hold_in_ready", {62'd0, in_ready, out_valid}, 64'd1);
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      check("quotient", {32'd0, quotient}, {32'd0, e.q});
      check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("after_handshake", {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  vec_t vecs[9];
  vec_t v;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs[0] = '{a: 32'h40C00000, b: 32'h40000000, q: 32'h40400000, dbz: 1'b0, lat: 26, hold: 0,  noise: 1'b0};
    vecs[1] = '{a: 32'h3F800000, b: 32'h40400000, q: 32'h3EAAAAAA, dbz: 1'b0, lat: 26, hold: 0,  noise: 1'b0};
    vecs[2] = '{a: 32'hBFC00000, b: 32'h3F000000, q: 32'hC0400000, dbz: 1'b0, lat: 26, hold: 0,  noise: 1'b0};
    vecs[3] = '{a: 32'h3F800000, b: 32'h00000000, q: 32'h7F800000, dbz: 1'b1, lat: 0,  hold: 0,  noise: 1'b0};
    vecs[4] = '{a: 32'h00000000, b: 32'hC0000000, q: 32'h80000000, dbz: 1'b0, lat: 0,  hold: 0,  noise: 1'b0};
    vecs[5] = '{a: 32'h7F000000, b: 32'h3E800000, q: 32'h7F800000, dbz: 1'b0, lat: 26, hold: 0,  noise: 1'b0};
    vecs[6] = '{a: 32'h00800000, b: 32'h40800000, q: 32'h00000000, dbz: 1'b0, lat: 26, hold: 0,  noise: 1'b0};
    vecs[7] = '{a: 32'h40C00000, b: 32'h40000000, q: 32'h40400000, dbz: 1'b0, lat: 26, hold: 10, noise: 1'b0};
    vecs[8] = '{a: 32'h3F800000, b: 32'h40400000, q: 32'h3EAAAAAA, dbz: 1'b0, lat: 26, hold: 0,  noise: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_quotient", {32'd0, quotient}, 64'd0);
    check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) issue(vecs[i]);

    // in_valid already high when out_ready completes: no same-edge accept
    v = '{a: 32'h40C00000, b: 32'h40000000, q: 32'h40400000, dbz: 1'b0, lat: 26, hold: 0, noise: 1'b0};
    issue(v);
    v = '{a: 32'h3F800000, b: 32'h00000000, q: 32'h7F800000, dbz: 1'b1, lat: 0, hold: 0, noise: 1'b0};
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("special_done", {62'd0, in_ready, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("no_overlap_accept", {62'd0, in_ready, out_valid}, 64'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next_cycle_accept", {62'd0, in_ready, out_valid}, 64'd1);
    check("next_cycle_dbz", {63'd0, div_by_zero}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during DIV aborts the operation without producing output
    @(negedge clk);
    dividend = 32'h40C00000;
    divisor  = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_op_busy", {62'd0, in_ready, out_valid}, 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_quotient", {32'd0, quotient}, 64'd0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_output", {63'd0, out_valid}, 64'd0);
    v = '{a: 32'h40C00000, b: 32'h40000000, q: 32'h40400000, dbz: 1'b0, lat: 26, hold: 0, noise: 1'b0};
    issue(v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
